regfile_access_ctrl: RTL and testbench

Access controller in front of the 8 x 16-bit register file. It shares the file's single write port and SR1 read port between the CPU control path and a debug load/dump port. It guarantees the debug port forward progress with a starvation timer, and sequences a hardware clear of R0..R7. It sits between the CPU control FSM/bus and the register file's DRMUX/SR1MUX/SR2/BUSINPUT/LD_REG inputs.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_starve_timer.sv | 41 ++++
 rtl/regfile_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned STARVE_W   = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } rfc_state_t;

endpackage

// File: rtl/regfile_starve_timer.sv
// Counts consecutive denied debug cycles and raises a one-cycle registered stall at the limit.
module regfile_starve_timer
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                waiting,
    input  logic                granted,
    input  logic                hold,
    input  logic [STARVE_W-1:0] limit,
    output logic                stall
);

    logic [STARVE_W-1:0] count_q, count_d;
    logic                stall_q;

    always_comb begin
        count_d = count_q;
        if (!hold) begin
            if (!waiting || granted) begin
                count_d = '0;
            end else if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // The stall lands in the same cycle the count reaches the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            count_q <= count_d;
            stall_q <= (count_d == limit);
        end
    end

    assign stall = stall_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates the register file write/SR1 ports between CPU and debug, with hardware clear.
// The clear sequence is built only when REGFILE_CLEAR_EN is defined.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       STARVE_LIMIT = 15,
    parameter logic [DATA_W-1:0] CLR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_ld,
    input  logic [REG_ADDR_W-1:0] cpu_dr,
    input  logic [DATA_W-1:0]     cpu_data,
    input  logic [REG_ADDR_W-1:0] cpu_sr1,
    input  logic [REG_ADDR_W-1:0] cpu_sr2,
    input  logic                  cpu_rd_en,
    output logic                  cpu_stall,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_wr,
    input  logic [REG_ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0]     dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    output logic [DATA_W-1:0]     dbg_rsp_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  rf_ld_reg,
    output logic [REG_ADDR_W-1:0] rf_drmux,
    output logic [DATA_W-1:0]     rf_businput,
    output logic [REG_ADDR_W-1:0] rf_sr1mux,
    output logic [REG_ADDR_W-1:0] rf_sr2,
    input  logic [DATA_W-1:0]     rf_sr1_out
);

    rfc_state_t      state_q;
    reg_addr_t       idx_q;
    logic            in_clear;
    logic            starve_stall;
    logic            cpu_wr_gnt, dbg_wr_gnt, dbg_rd_gnt;
    logic            rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef REGFILE_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (clr_start) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == REG_ADDR_W'(NUM_REGS - 1)) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign state_q          = IDLE;
    assign idx_q            = '0;
`endif

    assign in_clear = (state_q == CLEAR);

    // Grants are gated by reset so nothing reaches the file while reset is asserted.
    always_comb begin
        cpu_wr_gnt = 1'b0;
        dbg_wr_gnt = 1'b0;
        dbg_rd_gnt = 1'b0;
        if (reset && !in_clear) begin
            if (starve_stall && dbg_req_valid) begin
                dbg_wr_gnt = dbg_req_wr;
                dbg_rd_gnt = !dbg_req_wr;
            end else if (cpu_ld && !starve_stall) begin
                cpu_wr_gnt = 1'b1;
            end else if (dbg_req_valid && dbg_req_wr) begin
                dbg_wr_gnt = 1'b1;
            end else if (dbg_req_valid && !cpu_rd_en) begin
                dbg_rd_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        rf_ld_reg   = 1'b0;
        rf_drmux    = cpu_dr;
        rf_businput = cpu_data;
        rf_sr1mux   = cpu_sr1;
        if (in_clear) begin
            rf_ld_reg   = 1'b1;
            rf_drmux    = idx_q;
            rf_businput = CLR_VALUE;
        end else if (cpu_wr_gnt) begin
            rf_ld_reg = 1'b1;
        end else if (dbg_wr_gnt) begin
            rf_ld_reg   = 1'b1;
            rf_drmux    = dbg_req_addr;
            rf_businput = dbg_req_wdata;
        end
        if (dbg_rd_gnt) begin
            rf_sr1mux = dbg_req_addr;
        end
    end

    assign rf_sr2        = cpu_sr2;
    assign dbg_req_ready = dbg_wr_gnt | dbg_rd_gnt;
    assign cpu_stall     = starve_stall | in_clear;
    assign clr_busy      = in_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= dbg_rd_gnt;
            if (dbg_rd_gnt) begin
                rsp_rdata_q <= rf_sr1_out;
            end
        end
    end

    assign dbg_rsp_valid = rsp_valid_q;
    assign dbg_rsp_rdata = rsp_rdata_q;

    regfile_starve_timer u_starve_timer (
        .clk     (clk),
        .reset   (reset),
        .waiting (dbg_req_valid),
        .granted (dbg_req_ready),
        .hold    (in_clear),
        .limit   (STARVE_W'(STARVE_LIMIT)),
        .stall   (starve_stall)
    );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file and reference model.
module tb_regfile_access_ctrl;

    localparam int LIMIT = 15;
    localparam logic [15:0] CLRV = 16'h0000;
`ifdef REGFILE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_ld = 1'b0, cpu_rd_en = 1'b0;
    logic [2:0]  cpu_dr = '0, cpu_sr1 = '0, cpu_sr2 = '0;
    logic [15:0] cpu_data = '0;
    logic        cpu_stall;
    logic        dbg_req_valid = 1'b0, dbg_req_wr = 1'b0, dbg_req_ready;
    logic [2:0]  dbg_req_addr = '0;
    logic [15:0] dbg_req_wdata = '0;
    logic        dbg_rsp_valid;
    logic [15:0] dbg_rsp_rdata;
    logic        clr_start = 1'b0, clr_busy;
    logic        rf_ld_reg;
    logic [2:0]  rf_drmux, rf_sr1mux, rf_sr2;
    logic [15:0] rf_businput, rf_sr1_out;

    logic [15:0] rf [8] = '{default: 16'h0000};

    regfile_access_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_ld(cpu_ld), .cpu_dr(cpu_dr), .cpu_data(cpu_data),
        .cpu_sr1(cpu_sr1), .cpu_sr2(cpu_sr2), .cpu_rd_en(cpu_rd_en), .cpu_stall(cpu_stall),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_wr(dbg_req_wr),
        .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .rf_ld_reg(rf_ld_reg), .rf_drmux(rf_drmux), .rf_businput(rf_businput),
        .rf_sr1mux(rf_sr1mux), .rf_sr2(rf_sr2), .rf_sr1_out(rf_sr1_out)
    );

    always #5 clk = ~clk;

    // The register file itself: writes at the edge, combinational SR1 read.
    always @(posedge clk) if (rf_ld_reg) rf[rf_drmux] <= rf_businput;
    assign rf_sr1_out = rf[rf_sr1mux];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, passes = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference model state
    typedef struct { int c; logic [15:0] d; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] gold [8] = '{default: 16'h0000};
    bit          m_clear = 0, m_stall = 0, m_gnt = 0;
    int          m_idx = 0, m_starve = 0;
    bit          last_dut_ready = 0;
    int          busy_cnt = 0;

    task automatic model_reset();
        m_clear = 0; m_stall = 0; m_gnt = 0; m_idx = 0; m_starve = 0;
        exp_q.delete();
    endtask

    // Called at posedge+1 with inputs applied; checks at the negedge, returns at next posedge+1.
    task automatic step();
        bit dbg_ok, g_cpu, g_dw, g_dr;
        @(negedge clk);
        g_cpu = 0; g_dw = 0; g_dr = 0;
        if (!m_clear) begin
            // Debug may use the port if forced, or if the CPU is not writing (reads also need SR1 free).
            dbg_ok = dbg_req_valid && (m_stall || (!cpu_ld && (dbg_req_wr || !cpu_rd_en)));
            g_dw   = dbg_ok && dbg_req_wr;
            g_dr   = dbg_ok && !dbg_req_wr;
            g_cpu  = cpu_ld && !m_stall;
        end
        chk("ready", dbg_req_ready, 32'(g_dw | g_dr));
        chk("stall", cpu_stall, 32'(m_clear | m_stall));
        chk("busy", clr_busy, 32'(m_clear));
        chk("ld_reg", rf_ld_reg, 32'(m_clear | g_cpu | g_dw));
        last_dut_ready = dbg_req_ready;
        busy_cnt += int'(clr_busy);
        m_gnt = g_dw | g_dr;
        if (g_dr) exp_q.push_back('{c: cyc, d: gold[dbg_req_addr]});
        if (g_cpu) gold[cpu_dr] = cpu_data;
        if (g_dw) gold[dbg_req_addr] = dbg_req_wdata;
        if (m_clear) begin
            gold[m_idx] = CLRV;
            m_idx = (m_idx + 1) % 8;
            if (m_idx == 0) m_clear = 0;
        end else begin
            m_starve = (!dbg_req_valid || m_gnt) ? 0 : m_starve + 1;
            if (CLR_EN && clr_start) m_clear = 1;
        end
        m_stall = (m_starve == LIMIT);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is owed exactly one cycle after each predicted read grant.
    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].c < cyc - 1) begin
                chk("rsp_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc - 1) begin
                chk("rsp_valid", dbg_rsp_valid, 1);
                chk("rsp_rdata", dbg_rsp_rdata, exp_q[0].d);
                void'(exp_q.pop_front());
            end else if (dbg_rsp_valid) begin
                chk("rsp_unexpected", dbg_rsp_valid, 0);
            end
        end
    end

    task automatic idle();
        cpu_ld = 0; cpu_rd_en = 0; dbg_req_valid = 0; dbg_req_wr = 0; clr_start = 0;
    endtask

    task automatic dbg_op(input logic wr, input logic [2:0] a, input logic [15:0] d);
        idle();
        dbg_req_valid = 1; dbg_req_wr = wr; dbg_req_addr = a; dbg_req_wdata = d;
        step();
        for (int k = 0; k < 20 && !last_dut_ready; k++) step();
        if (!last_dut_ready) chk("dbg_op_timeout", 0, 1);
        idle();
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++) dbg_op(1'b0, 3'(r), 16'h0);
        step();
        step();
    endtask

    task automatic preload();
        for (int r = 0; r < 8; r++) dbg_op(1'b1, 3'(r), 16'(16'h1000 + r * 16'h0111 + 16'h5));
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        // Reset with a CPU write pending: nothing may reach the file.
        cpu_ld = 1; cpu_dr = 3'd1; cpu_data = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld_reg", rf_ld_reg, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_rsp_valid", dbg_rsp_valid, 0);
        chk("rst_rsp_rdata", dbg_rsp_rdata, 0);
        idle();
        reset = 1;
        step();

        // Debug write then read of R3.
        dbg_req_valid = 1; dbg_req_wr = 1; dbg_req_addr = 3'd3; dbg_req_wdata = 16'hBEEF;
        step();
        chk("beef_wr_ready", last_dut_ready, 1);
        dbg_req_wr = 0;
        step();
        chk("beef_rd_ready", last_dut_ready, 1);
        idle();
        step();
        chk("beef_rdata", dbg_rsp_rdata, 16'hBEEF);
        step();

        // CPU write held continuously starves a debug write until the forced stall.
        cpu_ld = 1; cpu_dr = 3'd5; cpu_data = 16'h1234;
        dbg_req_valid = 1; dbg_req_wr = 1; dbg_req_addr = 3'd2; dbg_req_wdata = 16'hABCD;
        for (i = 0; i < 30; i++) begin
            step();
            if (last_dut_ready) break;
        end
        chk("starve_wait", i + 1, LIMIT + 1);
        idle();
        step();
        dbg_op(1'b0, 3'd5, 16'h0);
        dbg_op(1'b0, 3'd2, 16'h0);
        step();
        chk("r2_rdata", dbg_rsp_rdata, 16'hABCD);
        step();

        // A debug read waits while the CPU consumes SR1.
        cpu_rd_en = 1; cpu_sr1 = 3'd1;
        dbg_req_valid = 1; dbg_req_wr = 0; dbg_req_addr = 3'd5;
        repeat (3) step();
        chk("rd_denied", last_dut_ready, 0);
        cpu_rd_en = 0;
        step();
        chk("rd_grant_same_cycle", last_dut_ready, 1);
        idle();
        step();
        chk("r5_rdata", dbg_rsp_rdata, 16'h1234);

        // Randomized traffic; requests are held until the model predicts acceptance.
        for (int n = 0; n < 1500; n++) begin
            if (!dbg_req_valid || m_gnt) begin
                dbg_req_valid = ($urandom_range(0, 2) != 0);
                dbg_req_wr    = $urandom_range(0, 1) == 1;
                dbg_req_addr  = 3'($urandom);
                dbg_req_wdata = 16'($urandom);
            end
            cpu_ld    = (n % 200 < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cpu_rd_en = $urandom_range(0, 1) == 1;
            cpu_dr    = 3'($urandom);
            cpu_data  = 16'($urandom);
            cpu_sr1   = 3'($urandom);
            cpu_sr2   = 3'($urandom);
            clr_start = ($urandom_range(0, 99) == 0);
            step();
            chk("sr2_pass", rf_sr2, cpu_sr2);
        end
        idle();
        repeat (10) step();
        read_all();

`ifdef REGFILE_CLEAR_EN
        // Full clear of preloaded registers.
        preload();
        busy_cnt = 0;
        clr_start = 1;
        step();
        clr_start = 0;
        repeat (10) step();
        chk("clr_busy_cycles", busy_cnt, 8);
        read_all();

        // Reset during the 4th clear cycle aborts the sequence.
        preload();
        clr_start = 1;
        step();
        clr_start = 0;
        repeat (3) step();
        reset = 0;
        #1;
        chk("abort_ld_reg", rf_ld_reg, 0);
        chk("abort_busy", clr_busy, 0);
        chk("abort_stall", cpu_stall, 0);
        chk("abort_rsp_valid", dbg_rsp_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        step();
        chk("abort_idle", clr_busy, 0);
        read_all();
`else
        // Without the clear feature a clr_start pulse does nothing.
        preload();
        busy_cnt = 0;
        clr_start = 1;
        step();
        clr_start = 0;
        repeat (10) step();
        chk("noclr_busy_cycles", busy_cnt, 0);
        read_all();
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
